// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared UART receive types and default parameters
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_WIDTH        = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - valid/ready byte output buffer of the UART receiver
interface uart_rx_ctrl_if
  import uart_rx_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// rtl/uart_rx_ctrl_sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module uart_rx_ctrl_sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start/stop validation, sipo shift control, output buffer
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_i,
  output logic             sipo_data_in_o,
  output logic             sipo_hold_o,
  input  logic [WIDTH-1:0] sipo_q_i,
  uart_rx_ctrl_if.master   out_if,
  output logic             frame_err_o,
  output logic             overrun_err_o,
  output logic             busy_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] data_q, data_d, rev;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_s, baud_done, shift, load;

  // Idle-high reset value keeps a reset from looking like a start bit.
  uart_rx_ctrl_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (baud_q == BAUD_HALF) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (baud_done) begin
        baud_d = '0;
        bit_d  = bit_q + 1'b1;
        if (bit_q == BIT_LAST) state_d = STOP;
      end
      STOP: if (baud_done) begin
        baud_d  = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        baud_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift       = 1'b0;
    load        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      DATA: shift = baud_done;
      STOP: begin
        load        = baud_done & rx_s;
        frame_err_d = baud_done & ~rx_s;
      end
      default: ;
    endcase

    // First wire bit sits in the sipo MSB; flip so it lands in the LSB.
    rev = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = sipo_q_i[WIDTH-1-i];

    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && out_if.data_ready) valid_d = 1'b0;
    if (load) begin
      data_d    = rev;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~out_if.data_ready;
    end
  end

  assign sipo_hold_o       = ~shift;
  assign sipo_data_in_o    = shift & rx_s;
  assign busy_o            = (state_q != IDLE);
  assign frame_err_o       = frame_err_q;
  assign overrun_err_o     = overrun_q;
  assign out_if.data_out   = data_q;
  assign out_if.data_valid = valid_q;

endmodule
